// File: rtl/dram_pkg.sv
// Shared types and default timing values for the DRAM timing controller.
// Optional build macro: DRAM_REF_POSTPONE_EN (refresh postponement counter).
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACT_W,
    WR_W,
    RD_W,
    PRE_W,
    REF_W
  } timing_state_t;

  localparam int T_RCD_DEF   = 14;
  localparam int T_CL_DEF    = 16;
  localparam int T_CWL_DEF   = 12;
  localparam int T_BURST_DEF = 4;
  localparam int T_WR_DEF    = 16;
  localparam int T_RP_DEF    = 14;
  localparam int T_RFC_DEF   = 280;
  localparam int T_REFI_DEF  = 6240;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/dram_timing_ctrl_if.sv
// Command strobes in, timing pulses and data-path windows out.
// Optional build macro: DRAM_REF_POSTPONE_EN adds ref_urgent.
interface dram_timing_ctrl_if;

  logic act_start;
  logic wr_start;
  logic rd_start;
  logic pre_start;
  logic ref_start;
  logic tACT_done;
  logic tWR_done;
  logic tRD_done;
  logic tPRE_done;
  logic tREF_done;
  logic rf_req;
  logic wr_en;
  logic rd_en;
  logic clear;
  logic busy;
  logic cmd_err;
`ifdef DRAM_REF_POSTPONE_EN
  logic ref_urgent;
`endif

  modport master (
    output act_start, wr_start, rd_start,
    output pre_start, ref_start,
    input  tACT_done, tWR_done, tRD_done,
    input  tPRE_done, tREF_done,
    input  rf_req, wr_en, rd_en, clear,
    input  busy, cmd_err
`ifdef DRAM_REF_POSTPONE_EN
    , input ref_urgent
`endif
  );

  modport slave (
    input  act_start, wr_start, rd_start,
    input  pre_start, ref_start,
    output tACT_done, tWR_done, tRD_done,
    output tPRE_done, tREF_done,
    output rf_req, wr_en, rd_en, clear,
    output busy, cmd_err
`ifdef DRAM_REF_POSTPONE_EN
    , output ref_urgent
`endif
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer and refresh-request tracking.
// Optional build macro: DRAM_REF_POSTPONE_EN (pending counter, ref_urgent).
module dram_refresh_timer
  import dram_pkg::*;
#(
  parameter int T_REFI = T_REFI_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic ref_start,
`ifdef DRAM_REF_POSTPONE_EN
  output logic ref_urgent,
`endif
  output logic rf_req
);

  logic [CNT_W-1:0] icnt;
  logic             wrap;

  assign wrap = (icnt == CNT_W'(T_REFI - 1));

  always_ff @(posedge CLK) begin
    if (RST)       icnt <= '0;
    else if (wrap) icnt <= '0;
    else           icnt <= icnt + CNT_W'(1);
  end

`ifdef DRAM_REF_POSTPONE_EN
  logic [3:0] pend;

  // wrap and ref_start together cancel out
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend <= '0;
    end else if (wrap && !ref_start) begin
      if (pend != 4'd8) pend <= pend + 4'd1;
    end else if (ref_start && !wrap) begin
      if (pend != 4'd0) pend <= pend - 4'd1;
    end
  end

  assign rf_req     = (pend != 4'd0);
  assign ref_urgent = pend[3];
`else
  logic req;

  // set wins over clear; wraps while pending are dropped
  always_ff @(posedge CLK) begin
    if (RST)            req <= 1'b0;
    else if (wrap)      req <= 1'b1;
    else if (ref_start) req <= 1'b0;
  end

  assign rf_req = req;
`endif

endmodule

// File: rtl/dram_timing_ctrl.sv
// Op timing FSM: counts command delays, drives done pulses and data windows.
// Optional build macro: DRAM_REF_POSTPONE_EN (forwarded to refresh timer).
module dram_timing_ctrl
  import dram_pkg::*;
#(
  parameter int T_RCD   = T_RCD_DEF,
  parameter int T_CL    = T_CL_DEF,
  parameter int T_CWL   = T_CWL_DEF,
  parameter int T_BURST = T_BURST_DEF,
  parameter int T_WR    = T_WR_DEF,
  parameter int T_RP    = T_RP_DEF,
  parameter int T_RFC   = T_RFC_DEF,
  parameter int T_REFI  = T_REFI_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic              CLK,
  input logic              RST,
  dram_timing_ctrl_if.slave bus
);

  // two extra bits hold the summed write delay
  localparam int W = CNT_W + 2;

  localparam logic [W-1:0] D_ACT = W'(T_RCD);
  localparam logic [W-1:0] D_PRE = W'(T_RP);
  localparam logic [W-1:0] D_REF = W'(T_RFC);
  localparam logic [W-1:0] D_RD  = W'(T_CL + T_BURST);
  localparam logic [W-1:0] D_WR  = W'(T_CWL + T_BURST + T_WR);
  localparam logic [W-1:0] R_LO  = W'(T_CL);
  localparam logic [W-1:0] W_LO  = W'(T_CWL);
  localparam logic [W-1:0] W_HI  = W'(T_CWL + T_BURST);

  timing_state_t state, state_n;
  logic [W-1:0]  cnt, cnt_n;
  logic [4:0]    starts;
  logic          term, free, multi, any, accept;

  assign starts = {bus.ref_start, bus.pre_start, bus.act_start,
                   bus.rd_start, bus.wr_start};
  assign any    = |starts;
  assign multi  = |(starts & (starts - 5'd1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    term    = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ACT_W:   term = (cnt == D_ACT);
      WR_W:    term = (cnt == D_WR);
      RD_W:    term = (cnt == D_RD);
      PRE_W:   term = (cnt == D_PRE);
      REF_W:   term = (cnt == D_REF);
      default: term = 1'b0;
    endcase
    free   = (state == IDLE) || term;
    accept = free && any && !RST;
    if (accept) begin
      cnt_n = W'(1);
      if (bus.ref_start)      state_n = REF_W;
      else if (bus.pre_start) state_n = PRE_W;
      else if (bus.act_start) state_n = ACT_W;
      else if (bus.rd_start)  state_n = RD_W;
      else                    state_n = WR_W;
    end else if (term) begin
      cnt_n   = '0;
      state_n = IDLE;
    end else if (state != IDLE) begin
      cnt_n = cnt + W'(1);
    end
  end

  assign bus.tACT_done = !RST && term && (state == ACT_W);
  assign bus.tWR_done  = !RST && term && (state == WR_W);
  assign bus.tRD_done  = !RST && term && (state == RD_W);
  assign bus.tPRE_done = !RST && term && (state == PRE_W);
  assign bus.tREF_done = !RST && term && (state == REF_W);
  assign bus.clear     = bus.tRD_done || bus.tWR_done;
  assign bus.busy      = !RST && ((state != IDLE && !term) || accept);
  assign bus.cmd_err   = !RST && any && (!free || multi);
  assign bus.rd_en     = !RST && (state == RD_W) &&
                         (cnt >= R_LO) && (cnt < D_RD);
  assign bus.wr_en     = !RST && (state == WR_W) &&
                         (cnt >= W_LO) && (cnt < W_HI);

  dram_refresh_timer #(
    .T_REFI (T_REFI),
    .CNT_W  (CNT_W)
  ) u_refresh (
    .CLK        (CLK),
    .RST        (RST),
    .ref_start  (bus.ref_start),
`ifdef DRAM_REF_POSTPONE_EN
    .ref_urgent (bus.ref_urgent),
`endif
    .rf_req     (bus.rf_req)
  );

endmodule
